// File: rtl/tdpr_port_arbiter_if.sv
// Client-side bus of the dual-port RAM arbiter: request/grant handshake
// and the per-requester read response lanes. Multi-requester fields are
// packed with requester i occupying slice [i*WIDTH +: WIDTH].
interface tdpr_port_arbiter_if #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4
);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_we;
    logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
    logic [NUM_REQ*DATA_SIZE-1:0] req_wdata;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [NUM_REQ*DATA_SIZE-1:0] rsp_rdata;

    // Client logic drives requests and consumes grants and responses.
    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    // The arbiter consumes requests and produces grants and responses.
    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/tdpr_port_arbiter.sv
// Shares one true dual-port RAM (1-cycle registered read) between NUM_REQ
// requesters. Up to two requests are granted per cycle in round-robin order:
// the first winner drives port A, the second drives port B. A port-B grant is
// withheld when it would touch the same address as port A with either side
// writing. Read data is steered back to the requester that issued the read.
module tdpr_port_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    tdpr_port_arbiter_if.slave   bus,
    output logic                 en_a,
    output logic                 we_a,
    output logic [ADDR_SIZE-1:0] addr_a,
    output logic [DATA_SIZE-1:0] din_a,
    input  logic [DATA_SIZE-1:0] dout_a,
    output logic                 en_b,
    output logic                 we_b,
    output logic [ADDR_SIZE-1:0] addr_b,
    output logic [DATA_SIZE-1:0] din_b,
    input  logic [DATA_SIZE-1:0] dout_b,
    output logic [15:0]          conflict_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    // Requester count widened by one bit so pointer arithmetic can be
    // compared against it without overflow.
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    // Modular add over requester indices. NUM_REQ need not be a power of
    // two, so wrap with an explicit compare rather than dropping carry bits.
    function automatic idx_t wrap_add(input idx_t base, input idx_t offs);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Round-robin start point and its next value.
    idx_t ptr_q;
    idx_t ptr_d;

    // Unpacked views of the per-requester request fields.
    logic [ADDR_SIZE-1:0] req_addr_arr  [NUM_REQ];
    logic [DATA_SIZE-1:0] req_wdata_arr [NUM_REQ];

    // Scan results: first and second valid requester from ptr onwards.
    idx_t cand;
    logic a_found;
    logic b_found;
    idx_t a_idx;
    idx_t b_idx;

    // Selected operands for each port.
    logic [ADDR_SIZE-1:0] a_addr;
    logic [ADDR_SIZE-1:0] b_addr;
    logic [DATA_SIZE-1:0] a_wdata;
    logic [DATA_SIZE-1:0] b_wdata;
    logic                 a_we;
    logic                 b_we;

    logic collision;
    logic b_grant;

    // In-flight read tags: which requester each port's read belongs to.
    logic rd_a_valid;
    idx_t rd_a_idx;
    logic rd_b_valid;
    idx_t rd_b_idx;

    // Response lanes and the per-requester held read data.
    logic [NUM_REQ-1:0]   rsp_valid_int;
    logic [DATA_SIZE-1:0] rsp_data_arr [NUM_REQ];
    logic [DATA_SIZE-1:0] held_q       [NUM_REQ];

    // Unpack the flat request buses into per-requester arrays.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr_arr[i]  = bus.req_addr[i*ADDR_SIZE +: ADDR_SIZE];
            req_wdata_arr[i] = bus.req_wdata[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    // Walk requesters in round-robin order from ptr and pick the first two
    // valid ones. Nothing is picked while reset is held.
    always_comb begin
        cand    = '0;
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = wrap_add(ptr_q, idx_t'(k));
                if (bus.req_valid[cand]) begin
                    if (!a_found) begin
                        a_found = 1'b1;
                        a_idx   = cand;
                    end else if (!b_found) begin
                        b_found = 1'b1;
                        b_idx   = cand;
                    end
                end
            end
        end
    end

    // Fetch the winners' operands and decide whether port B may proceed.
    // Two reads of one address are harmless; any write in the pair is not.
    always_comb begin
        a_addr    = req_addr_arr[a_idx];
        b_addr    = req_addr_arr[b_idx];
        a_wdata   = req_wdata_arr[a_idx];
        b_wdata   = req_wdata_arr[b_idx];
        a_we      = bus.req_we[a_idx];
        b_we      = bus.req_we[b_idx];
        collision = a_found && b_found && (a_addr == b_addr) && (a_we || b_we);
        b_grant   = b_found && !collision;
    end

    // Drive the RAM pins; an idle port is held fully quiet.
    always_comb begin
        en_a   = 1'b0;
        we_a   = 1'b0;
        addr_a = '0;
        din_a  = '0;
        en_b   = 1'b0;
        we_b   = 1'b0;
        addr_b = '0;
        din_b  = '0;
        if (a_found) begin
            en_a   = 1'b1;
            we_a   = a_we;
            addr_a = a_addr;
            din_a  = a_wdata;
        end
        if (b_grant) begin
            en_b   = 1'b1;
            we_b   = b_we;
            addr_b = b_addr;
            din_b  = b_wdata;
        end
    end

    // Grant vector back to the requesters.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((a_found && a_idx == idx_t'(i)) || (b_grant && b_idx == idx_t'(i))) begin
                bus.req_ready[i] = 1'b1;
            end
        end
    end

    // Next round-robin start: just past the last requester served this cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (b_grant) begin
            ptr_d = wrap_add(b_idx, idx_t'(1));
        end else if (a_found) begin
            ptr_d = wrap_add(a_idx, idx_t'(1));
        end
    end

    // Pointer and in-flight read tags, captured at the granting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            rd_a_valid <= 1'b0;
            rd_a_idx   <= '0;
            rd_b_valid <= 1'b0;
            rd_b_idx   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rd_a_valid <= a_found && !a_we;
            rd_a_idx   <= a_idx;
            rd_b_valid <= b_grant && !b_we;
            rd_b_idx   <= b_idx;
        end
    end

    // Steer RAM read data to the tagged requester. A reset arriving while a
    // read is in flight kills its response; otherwise the lane shows its
    // last delivered data.
    always_comb begin
        rsp_valid_int = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_data_arr[i] = held_q[i];
            if (!rst && rd_a_valid && rd_a_idx == idx_t'(i)) begin
                rsp_valid_int[i] = 1'b1;
                rsp_data_arr[i]  = dout_a;
            end else if (!rst && rd_b_valid && rd_b_idx == idx_t'(i)) begin
                rsp_valid_int[i] = 1'b1;
                rsp_data_arr[i]  = dout_b;
            end
        end
    end

    // Pack the response lanes onto the client bus.
    always_comb begin
        bus.rsp_valid = rsp_valid_int;
        bus.rsp_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_rdata[i*DATA_SIZE +: DATA_SIZE] = rsp_data_arr[i];
        end
    end

    // Remember each requester's most recent read data so it holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                held_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rsp_valid_int[i]) begin
                    held_q[i] <= rsp_data_arr[i];
                end
            end
        end
    end

    // Count cycles in which a port-B grant was withheld, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (collision && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_tdpr_port_arbiter.sv
// Bench for tdpr_port_arbiter: a behavioural dual-port RAM, a queue-based
// reference model compared against the DUT on every falling edge, and
// directed scenarios with hand-computed literal expectations.
module tb_tdpr_port_arbiter;

    localparam int ADDR_SIZE = 8;
    localparam int DATA_SIZE = 8;
    localparam int NUM_REQ   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ram_load = 1'b1;

    logic       en_a, we_a, en_b, we_b;
    logic [7:0] addr_a, din_a, dout_a, addr_b, din_b, dout_b;
    logic [15:0] conflict_cnt;

    int vec_count  = 0;
    int miss_count = 0;

    tdpr_port_arbiter_if #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE), .NUM_REQ(NUM_REQ)) bus ();

    tdpr_port_arbiter #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE), .NUM_REQ(NUM_REQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .en_a         (en_a),
        .we_a         (we_a),
        .addr_a       (addr_a),
        .din_a        (din_a),
        .dout_a       (dout_a),
        .en_b         (en_b),
        .we_b         (we_b),
        .addr_b       (addr_b),
        .din_b        (din_b),
        .dout_b       (dout_b),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Initial RAM contents, shared by the RAM model and the reference model.
    function automatic logic [7:0] preload(input int i);
        if (i == 1) return 8'h11;
        if (i == 2) return 8'h22;
        return 8'(i) ^ 8'h5A;
    endfunction

    // Behavioural dual-port RAM with a registered read.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= preload(i);
        end else begin
            if (en_a) begin
                if (we_a) ram[addr_a] <= din_a;
                else      dout_a <= ram[addr_a];
            end
            if (en_b) begin
                if (we_b) ram[addr_b] <= din_b;
                else      dout_b <= ram[addr_b];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] we,
                                 input logic [31:0] addrs, input logic [31:0] wdatas);
        bus.req_valid = valid;
        bus.req_we    = we;
        bus.req_addr  = addrs;
        bus.req_wdata = wdatas;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'b0, 4'b0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] addr_of(input int i);
        return bus.req_addr[i*ADDR_SIZE +: ADDR_SIZE];
    endfunction

    function automatic logic [7:0] wdata_of(input int i);
        return bus.req_wdata[i*DATA_SIZE +: DATA_SIZE];
    endfunction

    // Reference model state.
    logic [7:0] m_mem [256];
    logic [3:0] m_pend;
    logic [7:0] m_pend_data [NUM_REQ];
    logic [7:0] m_held [NUM_REQ];
    int         m_ptr;
    int         m_cnt;
    bit         check_en = 1'b0;
    bit         mem_init = 1'b0;
    int         order [$];
    int         ga, gb;
    bit         has_a, grant_b, coll;
    logic [3:0] e_ready;

    // Reference model: order the valid requesters from the pointer, take the
    // first two, apply the collision rule, then compare and advance.
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) m_mem[i] = preload(i);
            mem_init = 1'b1;
        end
        order.delete();
        has_a = 1'b0; grant_b = 1'b0; coll = 1'b0; ga = 0; gb = 0;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (bus.req_valid[(m_ptr + k) % NUM_REQ]) order.push_back((m_ptr + k) % NUM_REQ);
            end
        end
        if (order.size() > 0) begin
            has_a = 1'b1;
            ga = order[0];
        end
        if (order.size() > 1) begin
            gb = order[1];
            coll = (addr_of(ga) == addr_of(gb)) && (bus.req_we[ga] || bus.req_we[gb]);
            grant_b = !coll;
        end
        e_ready = 4'b0;
        if (has_a)   e_ready[ga] = 1'b1;
        if (grant_b) e_ready[gb] = 1'b1;

        if (check_en) begin
            checkOutput("req_ready", 32'(bus.req_ready), 32'(e_ready));
            checkOutput("en_a",   32'(en_a),   32'(has_a));
            checkOutput("we_a",   32'(we_a),   32'(has_a && bus.req_we[ga]));
            checkOutput("addr_a", 32'(addr_a), has_a ? 32'(addr_of(ga)) : 32'h0);
            checkOutput("din_a",  32'(din_a),  has_a ? 32'(wdata_of(ga)) : 32'h0);
            checkOutput("en_b",   32'(en_b),   32'(grant_b));
            checkOutput("we_b",   32'(we_b),   32'(grant_b && bus.req_we[gb]));
            checkOutput("addr_b", 32'(addr_b), grant_b ? 32'(addr_of(gb)) : 32'h0);
            checkOutput("din_b",  32'(din_b),  grant_b ? 32'(wdata_of(gb)) : 32'h0);
            for (int i = 0; i < NUM_REQ; i++) begin
                checkOutput($sformatf("rsp_valid[%0d]", i), 32'(bus.rsp_valid[i]), 32'(m_pend[i] && !rst));
                checkOutput($sformatf("rsp_rdata[%0d]", i), 32'(bus.rsp_rdata[i*DATA_SIZE +: DATA_SIZE]),
                            (m_pend[i] && !rst) ? 32'(m_pend_data[i]) : 32'(m_held[i]));
            end
            checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        end

        if (rst) begin
            m_ptr  = 0;
            m_pend = 4'b0;
            m_cnt  = 0;
            for (int i = 0; i < NUM_REQ; i++) m_held[i] = 8'h0;
            check_en = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) if (m_pend[i]) m_held[i] = m_pend_data[i];
            m_pend = 4'b0;
            if (has_a && !bus.req_we[ga]) begin
                m_pend[ga] = 1'b1;
                m_pend_data[ga] = m_mem[addr_of(ga)];
            end
            if (grant_b && !bus.req_we[gb]) begin
                m_pend[gb] = 1'b1;
                m_pend_data[gb] = m_mem[addr_of(gb)];
            end
            if (has_a && bus.req_we[ga])   m_mem[addr_of(ga)] = wdata_of(ga);
            if (grant_b && bus.req_we[gb]) m_mem[addr_of(gb)] = wdata_of(gb);
            if (grant_b)    m_ptr = (gb + 1) % NUM_REQ;
            else if (has_a) m_ptr = (ga + 1) % NUM_REQ;
            if (coll && m_cnt < 65535) m_cnt++;
        end
    end

    int resp_count [NUM_REQ];

    // Directed scenarios with literal expectations.
    initial begin
        applyStimulus(4'b0, 4'b0, 32'h0, 32'h0);
        nextCycle();
        ram_load = 1'b0;
        nextCycle();
        rst = 1'b0;

        $display("[TB] write then read from requester 0");
        doReset();
        applyStimulus(4'b0001, 4'b0001, 32'h0000_0010, 32'h0000_00A5);
        @(negedge clk);
        checkOutput("t1 ready wr", 32'(bus.req_ready), 32'h1);
        checkOutput("t1 we_a",     32'(we_a), 32'h1);
        checkOutput("t1 en_b",     32'(en_b), 32'h0);
        nextCycle();
        applyStimulus(4'b0001, 4'b0000, 32'h0000_0010, 32'h0);
        @(negedge clk);
        checkOutput("t1 ready rd", 32'(bus.req_ready), 32'h1);
        checkOutput("t1 addr_a",   32'(addr_a), 32'h10);
        nextCycle();
        applyStimulus(4'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t1 rsp_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("t1 rdata0",    32'(bus.rsp_rdata[7:0]), 32'hA5);
        nextCycle();
        @(negedge clk);
        checkOutput("t1 rsp idle",  32'(bus.rsp_valid), 32'h0);
        checkOutput("t1 rdata hold", 32'(bus.rsp_rdata[7:0]), 32'hA5);

        $display("[TB] dual reads, pointer advance, same-address reads");
        doReset();
        applyStimulus(4'b0011, 4'b0000, 32'h0000_0201, 32'h0);
        @(negedge clk);
        checkOutput("t2 ready", 32'(bus.req_ready), 32'h3);
        checkOutput("t2 addr_b", 32'(addr_b), 32'h02);
        nextCycle();
        applyStimulus(4'b0111, 4'b0000, 32'h0005_0403, 32'h0);
        @(negedge clk);
        checkOutput("t2 rsp_valid", 32'(bus.rsp_valid), 32'h3);
        checkOutput("t2 rdata0", 32'(bus.rsp_rdata[7:0]), 32'h11);
        checkOutput("t2 rdata1", 32'(bus.rsp_rdata[15:8]), 32'h22);
        checkOutput("t2 ready ptr2", 32'(bus.req_ready), 32'h5);
        checkOutput("t2 addr_a ptr2", 32'(addr_a), 32'h05);
        nextCycle();
        applyStimulus(4'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t2 rdata2", 32'(bus.rsp_rdata[23:16]), 32'h5F);
        checkOutput("t2 rdata0b", 32'(bus.rsp_rdata[7:0]), 32'h59);
        doReset();
        applyStimulus(4'b0011, 4'b0000, 32'h0000_0202, 32'h0);
        @(negedge clk);
        checkOutput("t2b ready", 32'(bus.req_ready), 32'h3);
        nextCycle();
        applyStimulus(4'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t2b rdata1", 32'(bus.rsp_rdata[15:8]), 32'h22);
        checkOutput("t2b conflict", 32'(conflict_cnt), 32'h0);

        $display("[TB] write-write collision");
        doReset();
        applyStimulus(4'b0011, 4'b0011, 32'h0000_2020, 32'h0000_4433);
        @(negedge clk);
        checkOutput("t3 ready", 32'(bus.req_ready), 32'h1);
        checkOutput("t3 en_b",  32'(en_b), 32'h0);
        nextCycle();
        applyStimulus(4'b0010, 4'b0010, 32'h0000_2020, 32'h0000_4433);
        @(negedge clk);
        checkOutput("t3 retry ready", 32'(bus.req_ready), 32'h2);
        checkOutput("t3 conflict", 32'(conflict_cnt), 32'h1);
        checkOutput("t3 din_a", 32'(din_a), 32'h44);
        nextCycle();
        applyStimulus(4'b0001, 4'b0000, 32'h0000_0020, 32'h0);
        @(negedge clk);
        checkOutput("t3 read ready", 32'(bus.req_ready), 32'h1);
        nextCycle();
        applyStimulus(4'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t3 rdata0", 32'(bus.rsp_rdata[7:0]), 32'h44);

        $display("[TB] write-read collision with read-after-write");
        doReset();
        applyStimulus(4'b1100, 4'b0100, 32'h3030_0000, 32'h0077_0000);
        @(negedge clk);
        checkOutput("t4 ready", 32'(bus.req_ready), 32'h4);
        checkOutput("t4 en_b", 32'(en_b), 32'h0);
        nextCycle();
        applyStimulus(4'b1000, 4'b0000, 32'h3030_0000, 32'h0);
        @(negedge clk);
        checkOutput("t4 retry ready", 32'(bus.req_ready), 32'h8);
        checkOutput("t4 conflict", 32'(conflict_cnt), 32'h1);
        nextCycle();
        applyStimulus(4'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t4 rsp_valid", 32'(bus.rsp_valid), 32'h8);
        checkOutput("t4 rdata3", 32'(bus.rsp_rdata[31:24]), 32'h77);
        nextCycle();

        $display("[TB] reset during in-flight read");
        applyStimulus(4'b0001, 4'b0000, 32'h0000_0001, 32'h0);
        @(negedge clk);
        checkOutput("t6 ready", 32'(bus.req_ready), 32'h1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(4'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t6 rsp in rst", 32'(bus.rsp_valid), 32'h0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6 rsp after", 32'(bus.rsp_valid), 32'h0);
        checkOutput("t6 conflict", 32'(conflict_cnt), 32'h0);
        nextCycle();
        applyStimulus(4'b1001, 4'b0000, 32'h0600_0005, 32'h0);
        @(negedge clk);
        checkOutput("t6 ptr0 addr_a", 32'(addr_a), 32'h05);
        checkOutput("t6 ptr0 ready", 32'(bus.req_ready), 32'h9);
        nextCycle();

        $display("[TB] four requesters streaming reads");
        doReset();
        for (int i = 0; i < NUM_REQ; i++) resp_count[i] = 0;
        applyStimulus(4'b1111, 4'b0000, 32'h4342_4140, 32'h0);
        for (int c = 0; c < 9; c++) begin
            if (c == 8) applyStimulus(4'b0, 4'b0, 32'h0, 32'h0);
            @(negedge clk);
            if (c < 8) begin
                checkOutput($sformatf("t5 ready c%0d", c), 32'(bus.req_ready), (c % 2 == 0) ? 32'h3 : 32'hC);
            end
            for (int i = 0; i < NUM_REQ; i++) if (bus.rsp_valid[i] === 1'b1) resp_count[i]++;
            nextCycle();
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            checkOutput($sformatf("t5 responses r%0d", i), 32'(resp_count[i]), 32'd4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
